// File: rtl/key_conditioner_pkg.sv
// ---- key_conditioner_pkg : shared state type and counter sizing helper (rev 1.0) ----
`default_nettype none

package key_conditioner_pkg;

  typedef enum logic [2:0] {
    RELEASED     = 3'd0,
    PRESS_WAIT   = 3'd1,
    HELD         = 3'd2,
    REPEATING    = 3'd3,
    RELEASE_WAIT = 3'd4
  } key_state_t;

  // Width able to hold the largest terminal count of the three timers.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_conditioner_if.sv
// ---- key_conditioner_if : key pins in, conditioned key events out (rev 1.0) ----
`default_nettype none

interface key_conditioner_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] i_key_in;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_strobe;

  modport master (
    output i_key_in,
    input  o_level, o_press, o_release, o_strobe
  );

  modport slave (
    input  i_key_in,
    output o_level, o_press, o_release, o_strobe
  );
endinterface

`default_nettype wire

// File: rtl/key_conditioner_channel.sv
// ---- key_channel : synchroniser, debounce FSM and auto-repeat for one key (rev 1.0) ----
`default_nettype none

module key_channel
  import key_conditioner_pkg::*;
#(
  parameter bit KEY_ACTIVE_LOW  = 1'b1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_strobe
);

  localparam int c_CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [c_CW-1:0] c_DEB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_CW-1:0] c_RD_LAST  = c_CW'(REPEAT_DELAY - 1);
  localparam logic [c_CW-1:0] c_RP_LAST  = c_CW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_k;
  key_state_t             r_state, w_state_nxt;
  logic [c_CW-1:0]        r_cnt, w_cnt_nxt;
  logic                   w_press_nxt, w_release_nxt, w_strobe_nxt, w_level_nxt;

  // r_k re-times the pressed flag so the FSM sees a clean registered sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync    <= {SYNC_STAGES{KEY_ACTIVE_LOW}};
      r_k       <= 1'b0;
      r_state   <= RELEASED;
      r_cnt     <= '0;
      o_level   <= 1'b0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_strobe  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_k       <= r_sync[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      o_level   <= w_level_nxt;
      o_press   <= w_press_nxt;
      o_release <= w_release_nxt;
      o_strobe  <= w_strobe_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_strobe_nxt  = 1'b0;
    case (r_state)
      RELEASED: begin
        if (r_k) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!r_k) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt  = HELD;
          w_cnt_nxt    = '0;
          w_press_nxt  = 1'b1;
          w_strobe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!r_k) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (!REPEAT_EN) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == c_RD_LAST) begin
          w_state_nxt  = REPEATING;
          w_cnt_nxt    = '0;
          w_strobe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      REPEATING: begin
        if (!r_k) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_RP_LAST) begin
          w_cnt_nxt    = '0;
          w_strobe_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed returns to HELD and restarts the repeat delay.
        if (r_k) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
    w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == REPEATING) ||
                  (w_state_nxt == RELEASE_WAIT);
  end

endmodule

`default_nettype wire

// File: rtl/key_conditioner.sv
// ---- key_conditioner : N independent key channels behind one interface (rev 1.0) ----
`default_nettype none

module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int              N_KEYS          = 4,
  parameter bit              KEY_ACTIVE_LOW  = 1'b1,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 250000,
  parameter int              REPEAT_DELAY    = 12500000,
  parameter int              REPEAT_PERIOD   = 2500000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = {N_KEYS{1'b1}}
) (
  input  logic             clock,
  input  logic             reset_n,
  key_conditioner_if.slave bus
);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("key_conditioner: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_chk_rd
    $error("key_conditioner: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_chk_rp
    $error("key_conditioner: REPEAT_PERIOD must be >= 1");
  end

  logic [N_KEYS-1:0] w_level, w_press, w_release, w_strobe;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_ch (
      .clock     (clock),
      .reset_n   (reset_n),
      .i_pin     (bus.i_key_in[i]),
      .o_level   (w_level[i]),
      .o_press   (w_press[i]),
      .o_release (w_release[i]),
      .o_strobe  (w_strobe[i])
    );
  end

  assign bus.o_level   = w_level;
  assign bus.o_press   = w_press;
  assign bus.o_release = w_release;
  assign bus.o_strobe  = w_strobe;

endmodule

`default_nettype wire

// File: tb/tb_key_conditioner.sv
// ---- tb_key_conditioner : scripted, table-driven and model-checked bench (rev 1.0) ----
`default_nettype none

module tb_key_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = 7;

  typedef struct {
    logic [3:0] keys;
    logic [3:0] exp_level;
    logic [3:0] exp_press;
    logic [3:0] exp_rel;
  } vec_t;

  logic       clock;
  logic       reset_n;
  logic       clk_run;
  logic [3:0] keys;

  int n_chk;
  int n_err;

  key_conditioner_if #(.N_KEYS(4)) if_a ();
  key_conditioner_if #(.N_KEYS(4)) if_b ();

  assign if_a.i_key_in = keys;
  assign if_b.i_key_in = keys;

  key_conditioner #(
    .N_KEYS(4), .KEY_ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(4'b1111)
  ) dut_a (.clock(clock), .reset_n(reset_n), .bus(if_a));

  key_conditioner #(
    .N_KEYS(4), .KEY_ACTIVE_LOW(1'b1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(4'b0001)
  ) dut_b (.clock(clock), .reset_n(reset_n), .bus(if_b));

  initial clock = 1'b0;
  always begin
    #5;
    if (clk_run) clock = ~clock;
  end

  // Reference: pin seen 3 edges late; level flips after DEB+1 consecutive
  // disagreeing samples; repeats are timed by edges since the last (re)entry to held.
  logic [3:0] p [3];
  logic [3:0] mask [2];
  bit         m_lvl [2][4];
  int         m_run [2][4];
  int         m_age [2][4];
  logic [3:0] e_level [2], e_press [2], e_rel [2], e_strobe [2];

  task automatic model_reset();
    for (int j = 0; j < 3; j++) p[j] = 4'hF;
    for (int d = 0; d < 2; d++) begin
      e_level[d] = '0; e_press[d] = '0; e_rel[d] = '0; e_strobe[d] = '0;
      for (int i = 0; i < 4; i++) begin
        m_lvl[d][i] = 1'b0; m_run[d][i] = 0; m_age[d][i] = 0;
      end
    end
  endtask

  task automatic model_step(input logic [3:0] kv);
    logic [3:0] kp;
    bit         k;
    kp   = p[2];
    p[2] = p[1];
    p[1] = p[0];
    p[0] = kv;
    for (int d = 0; d < 2; d++) begin
      e_press[d] = '0; e_rel[d] = '0; e_strobe[d] = '0;
      for (int i = 0; i < 4; i++) begin
        k = ~kp[i];
        if (k != m_lvl[d][i]) begin
          m_run[d][i]++;
          if (m_run[d][i] == DEB + 1) begin
            m_lvl[d][i] = k;
            m_run[d][i] = 0;
            m_age[d][i] = 0;
            if (k) begin
              e_press[d][i]  = 1'b1;
              e_strobe[d][i] = 1'b1;
            end else begin
              e_rel[d][i] = 1'b1;
            end
          end
        end else begin
          if (m_lvl[d][i]) begin
            if (m_run[d][i] > 0) m_age[d][i] = 0;
            else begin
              m_age[d][i]++;
              if (mask[d][i] && m_age[d][i] >= RD && (m_age[d][i] - RD) % RP == 0)
                e_strobe[d][i] = 1'b1;
            end
          end
          m_run[d][i] = 0;
        end
        e_level[d][i] = m_lvl[d][i];
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rep_due(input int s);
    return (s == 0) || (s >= RD && (s - RD) % RP == 0);
  endfunction

  // Called at a negedge: drive, clock once, advance model, compare at next negedge.
  task automatic tick(input logic [3:0] kv);
    keys = kv;
    @(posedge clock);
    model_step(kv);
    @(negedge clock);
    chk("model_a", {if_a.o_level, if_a.o_press, if_a.o_release, if_a.o_strobe},
        {e_level[0], e_press[0], e_rel[0], e_strobe[0]});
    chk("model_b", {if_b.o_level, if_b.o_press, if_b.o_release, if_b.o_strobe},
        {e_level[1], e_press[1], e_rel[1], e_strobe[1]});
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_a"}, {if_a.o_level, if_a.o_press, if_a.o_release, if_a.o_strobe}, 16'h0);
    chk({name, "_b"}, {if_b.o_level, if_b.o_press, if_b.o_release, if_b.o_strobe}, 16'h0);
  endtask

  task automatic after_reset_press();
    for (int n = 0; n < 10; n++) begin
      tick(4'hE);
      chk("rst_press", 16'(if_a.o_press), 16'((n == LAT) ? 4'h1 : 4'h0));
      chk("rst_strobe", 16'(if_a.o_strobe), 16'((n == LAT) ? 4'h1 : 4'h0));
      chk("rst_level", 16'(if_a.o_level), 16'((n >= LAT) ? 4'h1 : 4'h0));
    end
  endtask

  vec_t tbl [8];
  logic [3:0] acc_p, acc_r;

  initial begin
    n_chk = 0; n_err = 0;
    mask[0] = 4'hF; mask[1] = 4'h1;
    clk_run = 1'b1;
    reset_n = 1'b0;
    keys    = 4'hE;
    model_reset();
    tbl[0] = '{4'hF, 4'h0, 4'h0, 4'h0};
    tbl[1] = '{4'hE, 4'h1, 4'h1, 4'h0};
    tbl[2] = '{4'h6, 4'h9, 4'h8, 4'h0};
    tbl[3] = '{4'hF, 4'h0, 4'h0, 4'h9};
    tbl[4] = '{4'h0, 4'hF, 4'hF, 4'h0};
    tbl[5] = '{4'hA, 4'h5, 4'h0, 4'hA};
    tbl[6] = '{4'h5, 4'hA, 4'hA, 4'h5};
    tbl[7] = '{4'hF, 4'h0, 4'h0, 4'hA};

    // Reset held with key0 down, then press accepted after deassert.
    repeat (4) @(negedge clock);
    chk_zero("in_reset");
    reset_n = 1'b1;
    after_reset_press();

    // Release, then bounce, then press and hold through auto-repeat.
    for (int n = 0; n < 12; n++) tick(4'hF);
    tick(4'hE);
    chk("bounce_press", 16'(if_a.o_press), 16'h0);
    tick(4'hE);
    chk("bounce_press", 16'(if_a.o_press), 16'h0);
    tick(4'hF);
    chk("bounce_press", 16'(if_a.o_press), 16'h0);
    for (int n = 0; n < 48; n++) begin
      tick(4'hE);
      chk("hold_press", 16'(if_a.o_press[0]), 16'(n == LAT));
      chk("hold_strobe", 16'(if_a.o_strobe[0]), 16'(n >= LAT && rep_due(n - LAT)));
      chk("hold_level", 16'(if_a.o_level[0]), 16'(n >= LAT));
    end

    // Two-cycle release glitch while repeating: no release, repeat delay restarts.
    for (int m = 0; m < 18; m++) begin
      tick((m < 2) ? 4'hF : 4'hE);
      if (m >= 3) chk("glitch_strobe", 16'(if_a.o_strobe[0]), 16'(m == 15));
      chk("glitch_rel", 16'(if_a.o_release[0]), 16'h0);
      chk("glitch_level", 16'(if_a.o_level[0]), 16'h1);
    end
    for (int n = 0; n < 10; n++) begin
      tick(4'hF);
      chk("rel_pulse", 16'(if_a.o_release[0]), 16'(n == LAT));
      chk("rel_level", 16'(if_a.o_level[0]), 16'(n < LAT));
    end

    // Multi-channel vectors.
    for (int e = 0; e < 8; e++) begin
      acc_p = '0; acc_r = '0;
      for (int c = 0; c < 12; c++) begin
        tick(tbl[e].keys);
        acc_p |= if_a.o_press;
        acc_r |= if_a.o_release;
      end
      chk("tbl_level", 16'(if_a.o_level), 16'(tbl[e].exp_level));
      chk("tbl_press", 16'(acc_p), 16'(tbl[e].exp_press));
      chk("tbl_rel", 16'(acc_r), 16'(tbl[e].exp_rel));
    end

    // Partial repeat mask: keys 0 and 3 together, only key 0 repeats.
    for (int n = 0; n < 31; n++) begin
      tick(4'h6);
      chk("mask_press", 16'(if_b.o_press), 16'((n == LAT) ? 4'h9 : 4'h0));
      chk("mask_strobe3", 16'(if_b.o_strobe[3]), 16'(n == LAT));
      chk("mask_strobe0", 16'(if_b.o_strobe[0]), 16'(n >= LAT && rep_due(n - LAT)));
      chk("mask_level3", 16'(if_b.o_level[3]), 16'(n >= LAT));
    end
    for (int n = 0; n < 10; n++) begin
      tick(4'hF);
      chk("mask_rel", 16'(if_b.o_release), 16'((n == LAT) ? 4'h9 : 4'h0));
      chk("mask_rlevel3", 16'(if_b.o_level[3]), 16'(n < LAT));
    end

    // Asynchronous reset while repeating, clock stopped.
    for (int n = 0; n < 25; n++) tick(4'hE);
    chk("pre_reset_level", 16'(if_a.o_level[0]), 16'h1);
    clk_run = 1'b0;
    #20;
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset");
    model_reset();
    #20;
    reset_n = 1'b1;
    #3;
    chk_zero("reset_released");
    clk_run = 1'b1;
    after_reset_press();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
